// File: rtl/serial_sub.sv
// serial_sub: multi-cycle subtractor computing diff = a - b - bin, DIGIT bits
// per clock. The borrow ripples between slices through a register. The block
// reports the unsigned borrow-out and the signed overflow, and uses a
// start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dwork_q, dwork_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] a_k, b_k;
    logic [DIGIT:0]   sub_c;
    logic [WIDTH-1:0] dfull_c;
    logic             last_c;

    // Current slice: subtract at DIGIT+1 bits so the top bit is the borrow.
    // Also form the full difference with this slice merged in.
    always_comb begin
        a_k     = a_q[cnt_q*DIGIT +: DIGIT];
        b_k     = b_q[cnt_q*DIGIT +: DIGIT];
        sub_c   = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, brw_q};
        dfull_c = dwork_q;
        dfull_c[cnt_q*DIGIT +: DIGIT] = sub_c[DIGIT-1:0];
        last_c  = (cnt_q == CW'(STEPS - 1));
    end

    // Next-state logic: capture on start, one slice per RUN cycle,
    // and register the results on the last slice.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dwork_d = dwork_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dwork_d = dfull_c;
                brw_d   = sub_c[DIGIT];
                if (last_c) begin
                    diff_d  = dfull_c;
                    bout_d  = sub_c[DIGIT];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &
                              (dfull_c[WIDTH-1] != a_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation and
    // clears all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dwork_q <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dwork_q <= dwork_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
